// File: rtl/ss_seq_pkg.sv
// Shared types and constants for the save-state sequencer.
// SS_SEQ_CRC_EN adds the CRC trailer states to the state enum.
package ss_seq_pkg;

    localparam int SS_LEN_DEF   = 128;
    localparam int IDX_ADDR_DEF = 127;

    localparam logic [7:0] CRC8_POLY = 8'h07;

`ifdef SS_SEQ_CRC_EN
    typedef enum logic [3:0] {
        S_IDLE,
        S_D_RD,
        S_D_OUT,
        S_R_IN,
        S_R_WR,
        S_R_CHK,
        S_FIN,
        S_ERR,
        S_D_CRC,
        S_R_CRC
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_D_RD,
        S_D_OUT,
        S_R_IN,
        S_R_WR,
        S_R_CHK,
        S_FIN,
        S_ERR
    } state_t;
`endif

endpackage

// File: rtl/ss_seq_if.sv
// Command, mapper save-state and stream signals of one sequencer.
// master = sequencer side, slave = host/mapper side.
interface ss_seq_if;
    import ss_seq_pkg::*;

    logic       cmd_dump;
    logic       cmd_rest;
    logic       busy;
    logic       err;
    logic       done;
    logic       ss_act;
    logic [7:0] ss_addr;
    logic       ss_we;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic [7:0] map_idx;
    logic [7:0] o_dat;
    logic       o_vld;
    logic       o_rdy;
    logic [7:0] i_dat;
    logic       i_vld;
    logic       i_rdy;

    modport master (
        input  cmd_dump, cmd_rest, ss_rdat, map_idx,
        input  o_rdy, i_dat, i_vld,
        output busy, err, done, ss_act, ss_addr,
        output ss_we, ss_wdat, o_dat, o_vld, i_rdy
    );

    modport slave (
        output cmd_dump, cmd_rest, ss_rdat, map_idx,
        output o_rdy, i_dat, i_vld,
        input  busy, err, done, ss_act, ss_addr,
        input  ss_we, ss_wdat, o_dat, o_vld, i_rdy
    );

endinterface

// File: rtl/ss_seq_crc8.sv
// CRC-8 (poly 0x07, init 0, MSB-first) accumulator register.
// Only compiled when SS_SEQ_CRC_EN is defined.
`ifdef SS_SEQ_CRC_EN
module ss_crc8
    import ss_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] crc
);

    function automatic logic [7:0] crc8_next(
        input logic [7:0] c,
        input logic [7:0] d
    );
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ CRC8_POLY) : (r << 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_next(crc, din);
        end
    end

endmodule
`endif

// File: rtl/ss_seq.sv
// Save-state sequencer: dumps / restores mapper state bytes.
// SS_SEQ_CRC_EN appends and checks a CRC-8 trailer byte.
module ss_seq
    import ss_seq_pkg::*;
#(
    parameter int SS_LEN   = SS_LEN_DEF,
    parameter int IDX_ADDR = IDX_ADDR_DEF
)
(
    input  logic      clk,
    input  logic      rst_n,
    ss_seq_if.master  bus
);

    localparam logic [7:0] LAST = 8'(SS_LEN - 1);
    localparam logic [7:0] IDX  = 8'(IDX_ADDR);

    state_t state;
    logic   o_xfer;
    logic   i_xfer;

    assign o_xfer = bus.o_vld & bus.o_rdy;
    assign i_xfer = bus.i_vld & bus.i_rdy;

`ifdef SS_SEQ_CRC_EN
    logic [7:0] crc;
    logic       crc_clr;
    logic       crc_en;
    logic [7:0] crc_din;

    assign crc_clr = (state == S_IDLE) & (bus.cmd_dump | bus.cmd_rest);
    assign crc_en  = ((state == S_D_OUT) & o_xfer)
                   | ((state == S_R_IN) & i_xfer);
    assign crc_din = (state == S_D_OUT) ? bus.o_dat : bus.i_dat;

    ss_crc8 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (crc_din),
        .crc   (crc)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            bus.busy    <= 1'b0;
            bus.err     <= 1'b0;
            bus.done    <= 1'b0;
            bus.ss_act  <= 1'b0;
            bus.ss_addr <= 8'h00;
            bus.ss_we   <= 1'b0;
            bus.ss_wdat <= 8'h00;
            bus.o_dat   <= 8'h00;
            bus.o_vld   <= 1'b0;
            bus.i_rdy   <= 1'b0;
        end else begin
            bus.done  <= 1'b0;
            bus.ss_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.cmd_dump | bus.cmd_rest) begin
                        bus.ss_addr <= 8'h00;
                        bus.ss_act  <= 1'b1;
                        bus.busy    <= 1'b1;
                        bus.err     <= 1'b0;
                    end
                    if (bus.cmd_dump) begin
                        state <= S_D_RD;
                    end else if (bus.cmd_rest) begin
                        bus.i_rdy <= 1'b1;
                        state     <= S_R_IN;
                    end
                end
                S_D_RD: begin
                    bus.o_dat <= bus.ss_rdat;
                    bus.o_vld <= 1'b1;
                    state     <= S_D_OUT;
                end
                S_D_OUT: begin
                    if (o_xfer) begin
                        bus.o_vld <= 1'b0;
                        if (bus.ss_addr == LAST) begin
`ifdef SS_SEQ_CRC_EN
                            state <= S_D_CRC;
`else
                            bus.done   <= 1'b1;
                            bus.ss_act <= 1'b0;
                            bus.busy   <= 1'b0;
                            state      <= S_FIN;
`endif
                        end else begin
                            bus.ss_addr <= bus.ss_addr + 8'd1;
                            state       <= S_D_RD;
                        end
                    end
                end
                S_R_IN: begin
                    if (i_xfer) begin
                        bus.ss_wdat <= bus.i_dat;
                        bus.i_rdy   <= 1'b0;
                        if (bus.ss_addr == IDX) begin
                            state <= S_R_CHK;
                        end else begin
                            bus.ss_we <= 1'b1;
                            state     <= S_R_WR;
                        end
                    end
                end
                S_R_CHK: begin
                    // A foreign map_idx must never reach the mapper
                    if (bus.ss_wdat == bus.map_idx) begin
                        bus.ss_we <= 1'b1;
                        state     <= S_R_WR;
                    end else begin
                        bus.err    <= 1'b1;
                        bus.ss_act <= 1'b0;
                        bus.busy   <= 1'b0;
                        state      <= S_ERR;
                    end
                end
                S_R_WR: begin
                    if (bus.ss_addr == LAST) begin
`ifdef SS_SEQ_CRC_EN
                        bus.i_rdy <= 1'b1;
                        state     <= S_R_CRC;
`else
                        bus.done   <= 1'b1;
                        bus.ss_act <= 1'b0;
                        bus.busy   <= 1'b0;
                        state      <= S_FIN;
`endif
                    end else begin
                        bus.ss_addr <= bus.ss_addr + 8'd1;
                        bus.i_rdy   <= 1'b1;
                        state       <= S_R_IN;
                    end
                end
`ifdef SS_SEQ_CRC_EN
                S_D_CRC: begin
                    if (!bus.o_vld) begin
                        bus.o_dat <= crc;
                        bus.o_vld <= 1'b1;
                    end else if (o_xfer) begin
                        bus.o_vld  <= 1'b0;
                        bus.done   <= 1'b1;
                        bus.ss_act <= 1'b0;
                        bus.busy   <= 1'b0;
                        state      <= S_FIN;
                    end
                end
                S_R_CRC: begin
                    if (i_xfer) begin
                        bus.i_rdy  <= 1'b0;
                        bus.ss_act <= 1'b0;
                        bus.busy   <= 1'b0;
                        if (bus.i_dat == crc) begin
                            bus.done <= 1'b1;
                            state    <= S_FIN;
                        end else begin
                            bus.err <= 1'b1;
                            state   <= S_ERR;
                        end
                    end
                end
`endif
                S_FIN:   state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_seq.sv
// Directed self-checking bench for ss_seq (default parameters).
// Define SS_SEQ_CRC_EN to also cover the CRC trailer.
module tb_ss_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ss_seq_if bus();

    ss_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef SS_SEQ_CRC_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    int tests = 0;
    int fails = 0;

    logic       rdat_zero = 1'b0;
    logic       stall_en = 1'b0;
    int         sc = 0;
    logic [7:0] q[$];
    int         we_cnt, done_cnt, act_cnt, irdy_cnt, stab_err;
    logic [7:0] wr_data[256];
    bit         wr_flag[256];
    logic [7:0] rbuf[256];
    logic       p_vld = 1'b0;
    logic       p_rdy = 1'b0;
    logic [7:0] p_dat = 8'h00;
    logic [30:0] outs;

    // mapper model: state byte = address ^ 0x5A
    assign bus.ss_rdat = rdat_zero ? 8'h00 : (bus.ss_addr ^ 8'h5A);

    assign outs = {bus.busy, bus.err, bus.done, bus.ss_act,
                   bus.ss_addr, bus.ss_we, bus.ss_wdat,
                   bus.o_dat, bus.o_vld, bus.i_rdy};

    always @(negedge clk) begin
        if (stall_en) begin
            sc++;
            if (sc == 3) begin
                sc = 0;
                bus.o_rdy = ~bus.o_rdy;
            end
        end else begin
            sc = 0;
            bus.o_rdy = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.o_vld && bus.o_rdy) q.push_back(bus.o_dat);
            if (bus.ss_we) begin
                we_cnt++;
                wr_flag[bus.ss_addr] = 1'b1;
                wr_data[bus.ss_addr] = bus.ss_wdat;
            end
            if (bus.done) done_cnt++;
            if (bus.ss_act) act_cnt++;
            if (bus.i_rdy) irdy_cnt++;
            if (p_vld && !p_rdy &&
                (bus.o_vld !== 1'b1 || bus.o_dat !== p_dat))
                stab_err++;
            p_vld = bus.o_vld;
            p_rdy = bus.o_rdy;
            p_dat = bus.o_dat;
        end else begin
            p_vld = 1'b0;
        end
    end

    function automatic logic [7:0] crc_model(
        input logic [7:0] c,
        input logic [7:0] d
    );
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    task automatic clr_mon();
        q.delete();
        we_cnt = 0;
        done_cnt = 0;
        act_cnt = 0;
        irdy_cnt = 0;
        stab_err = 0;
        for (int i = 0; i < 256; i++) begin
            wr_flag[i] = 1'b0;
            wr_data[i] = 8'h00;
        end
    endtask

    task automatic pulse(input bit d, input bit r);
        @(negedge clk);
        bus.cmd_dump = d;
        bus.cmd_rest = r;
        @(negedge clk);
        bus.cmd_dump = 1'b0;
        bus.cmd_rest = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int c = 0;
        while (done_cnt == 0 && bus.err !== 1'b1 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (c >= 3000) begin
            fails++;
            $display("FAIL %s_end: timeout after %0d cycles", nm, c);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic feed(input string nm, input int n);
        int idx = 0;
        int c = 0;
        while (idx < n && c < 4000 && bus.err !== 1'b1) begin
            @(negedge clk);
            bus.i_dat = rbuf[idx];
            bus.i_vld = 1'b1;
            @(posedge clk);
            if (bus.i_rdy) idx++;
            c++;
        end
        @(negedge clk);
        bus.i_vld = 1'b0;
        tests++;
        if (c >= 4000) begin
            fails++;
            $display("FAIL %s_feed: timeout, sent %0d of %0d", nm, idx, n);
        end
    endtask

    task automatic fill_rbuf(input logic [7:0] last);
        logic [7:0] c;
        for (int i = 0; i < 127; i++) rbuf[i] = 8'(i * 7 + 3);
        rbuf[127] = last;
        c = 8'h00;
        for (int i = 0; i < 128; i++) c = crc_model(c, rbuf[i]);
        rbuf[128] = c;
    endtask

    task automatic check_dump(input string nm);
        int bad = 0;
        tests++;
        if (q.size() != 128 + EXTRA) begin
            fails++;
            $display("FAIL %s_count: got %0d bytes, expected %0d",
                     nm, q.size(), 128 + EXTRA);
        end
        for (int i = 0; i < 128; i++)
            if (i >= q.size() || q[i] !== (8'(i) ^ 8'h5A)) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_data: %0d bad bytes, expected 0", nm, bad);
        end
`ifdef SS_SEQ_CRC_EN
        begin
            logic [7:0] c;
            c = 8'h00;
            for (int i = 0; i < 128; i++) c = crc_model(c, 8'(i) ^ 8'h5A);
            tests++;
            if (q.size() < 129 || q[128] !== c) begin
                fails++;
                $display("FAIL %s_crc: got %h, expected %h",
                         nm, (q.size() > 128) ? q[128] : 8'hxx, c);
            end
        end
`endif
        tests++;
        if (done_cnt != 1 || we_cnt != 0) begin
            fails++;
            $display("FAIL %s_flags: done=%0d we=%0d, expected 1 0",
                     nm, done_cnt, we_cnt);
        end
        tests++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.ss_act !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: err=%b busy=%b act=%b, expected 0 0 0",
                     nm, bus.err, bus.busy, bus.ss_act);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_out: got %h, expected 0", outs);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_idle: got %h, expected 0", outs);
        end
    endtask

    task automatic test_dump();
        clr_mon();
        pulse(1'b1, 1'b0);
        wait_end("dump");
        check_dump("dump");
        tests++;
        if (act_cnt != 256 + 2 * EXTRA) begin
            fails++;
            $display("FAIL dump_act: got %0d cycles, expected %0d",
                     act_cnt, 256 + 2 * EXTRA);
        end
    endtask

    task automatic test_dump_stall();
        clr_mon();
        stall_en = 1'b1;
        pulse(1'b1, 1'b0);
        wait_end("stall");
        stall_en = 1'b0;
        check_dump("stall");
        tests++;
        if (stab_err != 0) begin
            fails++;
            $display("FAIL stall_hold: %0d unstable cycles, expected 0",
                     stab_err);
        end
    endtask

    task automatic test_priority_reset();
        int c = 0;
        int bad = 0;
        clr_mon();
        pulse(1'b1, 1'b1);
        tests++;
        if (bus.busy !== 1'b1 || bus.ss_act !== 1'b1 || bus.i_rdy !== 1'b0) begin
            fails++;
            $display("FAIL prio_accept: busy=%b act=%b irdy=%b, expected 1 1 0",
                     bus.busy, bus.ss_act, bus.i_rdy);
        end
        while (q.size() < 10 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        pulse(1'b0, 1'b1);
        while (q.size() < 40 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (c >= 1000) begin
            fails++;
            $display("FAIL prio_wait: timeout with %0d bytes", q.size());
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL midrst_async: got %h, expected 0", outs);
        end
        @(negedge clk);
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL midrst_next: got %h, expected 0", outs);
        end
        for (int i = 0; i < 40; i++)
            if (q[i] !== (8'(i) ^ 8'h5A)) bad++;
        tests++;
        if (bad != 0 || irdy_cnt != 0 || we_cnt != 0) begin
            fails++;
            $display("FAIL prio_dump: bad=%0d irdy=%0d we=%0d, expected 0 0 0",
                     bad, irdy_cnt, we_cnt);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_writes(input string nm);
        int bad = 0;
        for (int i = 0; i < 128; i++)
            if (!wr_flag[i] || wr_data[i] !== rbuf[i]) bad++;
        tests++;
        if (we_cnt != 128 || bad != 0) begin
            fails++;
            $display("FAIL %s_wr: we=%0d bad=%0d, expected 128 0",
                     nm, we_cnt, bad);
        end
        tests++;
        if (done_cnt != 1 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_end: done=%0d err=%b busy=%b, expected 1 0 0",
                     nm, done_cnt, bus.err, bus.busy);
        end
    endtask

    task automatic test_restore_ok();
        bus.map_idx = 8'h24;
        fill_rbuf(8'h24);
        clr_mon();
        pulse(1'b0, 1'b1);
        feed("rest", 128 + EXTRA);
        wait_end("rest");
        check_writes("rest");
    endtask

    task automatic test_restore_bad();
        bus.map_idx = 8'h24;
        fill_rbuf(8'h25);
        clr_mon();
        pulse(1'b0, 1'b1);
        feed("bad", 128 + EXTRA);
        wait_end("bad");
        tests++;
        if (we_cnt != 127 || wr_flag[127] !== 1'b0) begin
            fails++;
            $display("FAIL bad_wr: we=%0d wr127=%b, expected 127 0",
                     we_cnt, wr_flag[127]);
        end
        tests++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 ||
            bus.ss_act !== 1'b0 || done_cnt != 0) begin
            fails++;
            $display("FAIL bad_state: err=%b busy=%b act=%b done=%0d, expected 1 0 0 0",
                     bus.err, bus.busy, bus.ss_act, done_cnt);
        end
        fill_rbuf(8'h24);
        clr_mon();
        pulse(1'b0, 1'b1);
        tests++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL bad_clear: err=%b busy=%b, expected 0 1",
                     bus.err, bus.busy);
        end
        feed("retry", 128 + EXTRA);
        wait_end("retry");
        check_writes("retry");
    endtask

`ifdef SS_SEQ_CRC_EN
    task automatic test_crc();
        rdat_zero = 1'b1;
        clr_mon();
        pulse(1'b1, 1'b0);
        wait_end("crcz");
        rdat_zero = 1'b0;
        tests++;
        if (q.size() != 129 || q[128] !== 8'h00 || done_cnt != 1) begin
            fails++;
            $display("FAIL crcz_dump: n=%0d done=%0d, expected 129 1",
                     q.size(), done_cnt);
        end
        bus.map_idx = 8'h00;
        for (int i = 0; i < 128; i++) rbuf[i] = 8'h00;
        rbuf[128] = 8'hFF;
        clr_mon();
        pulse(1'b0, 1'b1);
        feed("crcbad", 129);
        wait_end("crcbad");
        tests++;
        if (bus.err !== 1'b1 || done_cnt != 0 || we_cnt != 128) begin
            fails++;
            $display("FAIL crcbad_rest: err=%b done=%0d we=%0d, expected 1 0 128",
                     bus.err, done_cnt, we_cnt);
        end
        bus.map_idx = 8'h24;
    endtask
`endif

    initial begin
        bus.cmd_dump = 1'b0;
        bus.cmd_rest = 1'b0;
        bus.i_vld = 1'b0;
        bus.i_dat = 8'h00;
        bus.map_idx = 8'h24;
        clr_mon();
        test_reset();
        test_dump();
        test_dump_stall();
        test_priority_reset();
        test_restore_ok();
        test_restore_bad();
`ifdef SS_SEQ_CRC_EN
        test_crc();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ss_seq.md
Name: ss_seq

Overview:
- Save-state sequencer: the initiator side of the mapper save-state port (ss_act / ss_addr / ss_we / write data / ss_rdat).
- DUMP walks mapper state addresses 0..SS_LEN-1, reads each byte, and streams it out.
- RESTORE accepts a byte stream and writes each byte back with one ss_we strobe per address.
- Sits between the host/menu DMA and the active mapper; one instance per mapper slot.

Parameters:
- SS_LEN, 128, number of state bytes per mapper (addresses 0..SS_LEN-1); must be 2..256.
- IDX_ADDR, 127, address holding map_idx; checked on restore.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_dump  in  1  one-cycle pulse, start dump; ignored unless IDLE
- cmd_rest  in  1  one-cycle pulse, start restore; ignored unless IDLE; cmd_dump wins if both pulse together
- busy  out  1  high from command accept until return to IDLE
- err  out  1  sticky; cleared by next accepted command
- done  out  1  one-cycle pulse on successful completion
- ss_act  out  1  mapper in save-state mode
- ss_addr  out  8  state address
- ss_we  out  1  one-cycle write strobe to mapper
- ss_wdat  out  8  write data to mapper
- ss_rdat  in  8  mapper read data, combinational from ss_addr
- map_idx  in  8  live mapper index
- o_dat, o_vld, o_rdy  out,out,in  8,1,1  dump stream
- i_dat, i_vld, i_rdy  in,in,out  8,1,1  restore stream

Behaviour:
- Reset: state IDLE. All outputs 0 (busy, err, done, ss_act, ss_addr, ss_we, ss_wdat, o_dat, o_vld, i_rdy).
- Stream transfer occurs on a cycle with vld&rdy high.
- o_dat and o_vld stay stable while o_vld=1 and o_rdy=0.
- States: IDLE, D_RD, D_OUT, R_IN, R_WR, R_CHK, FIN, ERR.
- IDLE:
  - cmd_dump → D_RD, ss_addr=0, ss_act=1, busy=1, err=0.
  - cmd_rest → R_IN, same ss_addr/ss_act/busy/err settings.
- D_RD: one settle cycle; register ss_rdat into o_dat, assert o_vld → D_OUT.
- D_OUT: on transfer:
  - if ss_addr==SS_LEN-1 → FIN;
  - else ss_addr+1 → D_RD.
  - Throughput: 1 byte per 2 cycles.
- R_IN: i_rdy=1. On transfer, latch i_dat into ss_wdat.
  - If ss_addr==IDX_ADDR → R_CHK.
  - Else → R_WR.
- R_CHK: compare ss_wdat with map_idx.
  - Equal → R_WR.
  - Unequal → ERR; no write is issued.
- R_WR: ss_we=1 for exactly one cycle.
  - Then ss_addr==SS_LEN-1 → FIN; else ss_addr+1 → R_IN.
  - i_rdy=0 in R_CHK and R_WR.
- FIN: done=1 for one cycle, ss_act=0, busy=0 → IDLE.
- ERR: err=1 (sticky), ss_act=0, busy=0 → IDLE.
  - Mapper registers already written stay written; the host must re-restore or reset the mapper.
- ss_addr is 8-bit and never wraps: the terminal compare happens before increment.
- ss_act is high throughout every non-IDLE state except FIN/ERR. It never drops mid-sequence.
- Commands arriving while busy are dropped; no queueing.
- rst_n assertion mid-sequence: immediate return to reset values. Mapper leaves ss mode on that same edge.

Optional Feature:
- Macro SS_SEQ_CRC_EN.
- With it, a CRC-8 (poly 0x07, init 0x00, MSB-first) accumulates every streamed state byte.
  - Dump: after the last state byte, one extra byte carrying the CRC is emitted (state D_CRC) before FIN.
  - Restore: one extra byte is expected after the last write (state R_CRC, i_rdy=1).
    - Mismatch → ERR.
    - Match → FIN.
  - The CRC resets on command accept.
- Without it: exactly SS_LEN bytes each direction. No CRC states or logic are present.

Decomposition:
- Package ss_seq_pkg: state enum, CRC8_POLY=8'h07, default SS_LEN/IDX_ADDR constants.
- Sub-module ss_crc8: byte-wide combinational next-CRC function plus register, clear/enable inputs. Instantiated only under SS_SEQ_CRC_EN.

Test Plan:
- Dump, mapper model returns addr^8'h5A, o_rdy=1 → 128 bytes 0x5A,0x5B,…; done pulses once; ss_act high for 256 cycles.
- Dump with o_rdy toggling every 3 cycles → o_dat held stable while stalled; byte sequence unchanged; no ss_we ever.
- Restore 128 bytes with byte127=map_idx=0x24 → 128 ss_we pulses at ss_addr 0..127 carrying the fed data; done=1; err=0.
- Restore with byte127=0x25, map_idx=0x24 → 127 writes, no write at 127; err=1; busy drops; second cmd_rest clears err.
- cmd_dump and cmd_rest in the same cycle → dump runs; cmd_rest pulsed mid-dump is ignored; rst_n low at byte 40 → all outputs 0 next cycle.
- With SS_SEQ_CRC_EN: dump of all-zero state → 129th byte 0x00; restore with corrupted CRC byte → err=1, done=0.
